// File: rtl/CORE_PKG.sv
// Core-wide sizing constants shared by the backend units.
package CORE_PKG;
    parameter int unsigned NUM_PREGS = 64;
endpackage

// File: rtl/fwrd_unit.sv
// Forwarding responder for register read: holds writeback results for
// FWD_STAGES cycles and returns the youngest matching value per source tag.
module fwrd_unit #(
    parameter int unsigned NUM_PREGS  = CORE_PKG::NUM_PREGS,
    parameter int unsigned NUM_WB     = 2,
    parameter int unsigned FWD_STAGES = 2,
    localparam int unsigned PW        = $clog2(NUM_PREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB-1:0][PW-1:0]      wb_preg,
    input  logic [NUM_WB-1:0][31:0]        wb_data,
    input  logic [PW-1:0]                  src1_reg,
    input  logic [PW-1:0]                  src2_reg,
    output logic                           src1_fwrd_hit,
    output logic                           src2_fwrd_hit,
    output logic [31:0]                    src1_val,
    output logic [31:0]                    src2_val
);

    localparam int unsigned NCAND = (1 + FWD_STAGES) * NUM_WB;

    logic [FWD_STAGES-1:0][NUM_WB-1:0]         stg_valid;
    logic [FWD_STAGES-1:0][NUM_WB-1:0][PW-1:0] stg_preg;
    logic [FWD_STAGES-1:0][NUM_WB-1:0][31:0]   stg_data;

    logic [NCAND-1:0]         cand_valid;
    logic [NCAND-1:0][PW-1:0] cand_preg;
    logic [NCAND-1:0][31:0]   cand_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stg_valid <= '0;
        end else begin
            stg_valid[0] <= wb_valid;
            for (int unsigned k = 1; k < FWD_STAGES; k++) begin
                stg_valid[k] <= stg_valid[k-1];
            end
        end
    end

    // Payload shifts unconditionally; only the valid bits carry meaning.
    always_ff @(posedge clk) begin
        stg_preg[0] <= wb_preg;
        stg_data[0] <= wb_data;
        for (int unsigned k = 1; k < FWD_STAGES; k++) begin
            stg_preg[k] <= stg_preg[k-1];
            stg_data[k] <= stg_data[k-1];
        end
    end

    // Flattened so that candidate index order is priority order: bus first,
    // then stage 0 upward, lower port index first within each level.
    assign cand_valid = {stg_valid, wb_valid};
    assign cand_preg  = {stg_preg, wb_preg};
    assign cand_data  = {stg_data, wb_data};

    always_comb begin
        src1_fwrd_hit = 1'b0;
        src1_val      = '0;
        src2_fwrd_hit = 1'b0;
        src2_val      = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NCAND; i++) begin
                if (!src1_fwrd_hit && cand_valid[i] && (src1_reg != '0) &&
                    (cand_preg[i] == src1_reg)) begin
                    src1_fwrd_hit = 1'b1;
                    src1_val      = cand_data[i];
                end
                if (!src2_fwrd_hit && cand_valid[i] && (src2_reg != '0) &&
                    (cand_preg[i] == src2_reg)) begin
                    src2_fwrd_hit = 1'b1;
                    src2_val      = cand_data[i];
                end
            end
        end
    end

endmodule

// File: doc/fwrd_unit.md
# fwrd_unit

Forwarding unit for the register-read stage: the responder side of the forwarding request/response exchange with register read. It captures every writeback result while that result is still in flight to the physical register file. For the two source physical registers presented by register read, it returns a hit flag and the value, youngest producer first. It sits between the writeback buses and the register-read stage, so issued ops never wait on regfile write latency.

## Interface
Parameters:
- NUM_PREGS, CORE_PKG::NUM_PREGS: physical register count. Tag width PW = $clog2(NUM_PREGS).
- NUM_WB, 2: number of writeback result ports.
- FWD_STAGES, 2: number of cycles a result is held after its writeback cycle, equal to the regfile write-to-read latency.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; clears all held results.
- wb_valid  in  NUM_WB  writeback valid, one bit per port.
- wb_preg  in  NUM_WB x PW  destination physical register per port.
- wb_data  in  NUM_WB x 32  result value per port.
- src1_reg, src2_reg  in  PW  lookup tags driven by register read.
- src1_fwrd_hit, src2_fwrd_hit  out  1  lookup hit.
- src1_val, src2_val  out  32  forwarded value; 0 when there is no hit.

## Operation
- Storage is a shift pipeline of FWD_STAGES stages. Each stage holds NUM_WB entries of {valid, preg, data}.
- Stage 0 captures the current cycle's wb_valid/preg/data at the clock edge. Stage k captures stage k-1.
- The entries in the last stage drop out on the next edge. By then the regfile holds the value.
- Lookup is combinational, evaluated independently for each source. Candidates, in priority order:
  - the live wb bus (current cycle),
  - then stage 0, stage 1, …, stage FWD_STAGES-1.
- First valid candidate with a matching preg wins. Within one level, the lower port index wins.
- Tag 0 (the hardwired zero register) never hits, even if a writeback targets it.
- No hit: hit = 0, val = 32'h0.
- Two ports writing the same preg in the same cycle is illegal under renaming. Hardware resolves it by lower-index priority; the bench asserts it never happens.
- Flush:
  - All stage valids clear at the edge where flush = 1.
  - The wb bus in the flush cycle is not captured.
  - Combinational lookup during the flush cycle is unaffected: the live bus and the current stages still hit.
- rst:
  - All stage valids clear at the edge.
  - While rst = 1, both hit outputs are forced to 0 and both vals to 0, regardless of the bus or stage contents.
  - Reset and flush together behave as reset.
- Stage data registers need no reset; only the valid bits reset.

## Timing
- Lookup latency is 0 cycles: the outputs settle in the same cycle that src*_reg and the wb bus are presented.
- A writeback in cycle t hits through the live bus in cycle t, and through stage k-1 in cycle t+k, for k = 1..FWD_STAGES.
- From cycle t+FWD_STAGES+1 the value comes from the regfile; the unit no longer hits on it.
- A preg rewritten by a newer writeback returns the newest value. The older copy in a deeper stage is shadowed, not invalidated.
- Both lookups are fully independent. src1_reg == src2_reg returns identical results on both outputs.
- The critical path is the (1+FWD_STAGES)*NUM_WB-way tag compare plus the priority mux. There are no registered outputs.

## Test plan
- Bus hit: wb_valid=2'b01, wb_preg[0]=5, wb_data[0]=32'hDEADBEEF, src1_reg=5 in the same cycle -> src1_fwrd_hit=1, src1_val=32'hDEADBEEF. src2_reg=6 -> hit 0, val 0.
- Lifetime: write preg 9 = 32'h11 in cycle t, no further writebacks -> src1 hits with 32'h11 in cycles t, t+1 and t+2; hit=0 in cycle t+3 (FWD_STAGES=2).
- Priority: preg 7 = 32'hA in cycle t, preg 7 = 32'hB on port 1 in cycle t+1 -> src1_val=32'hB in cycles t+1..t+3, then no hit in t+4. Same setup with lookup in cycle t -> 32'hA.
- Zero tag: wb_preg[0]=0 with data 32'h55, src1_reg=0 -> hit 0 in every cycle.
- Flush: preg 3 written in cycle t, flush=1 in cycle t+1 -> hit in t and t+1; no hit in t+2. A writeback presented in t+1 is not held in t+2.
- Reset mid-operation: stages full of valid entries, rst=1 for one cycle while the bus drives preg 4 -> outputs 0 during rst. The cycle after reset, src1_reg=4 misses.
